gray_rx: RTL and testbench

//   Receiving end of the Gray-coded counter bus. Synchronises a free-running

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_sync.sv | 25 ++
 rtl/gray_rx.sv | 122 ++++++++++++
 tb/tb_gray_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-count receiver.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } rx_state_e;

  localparam int ERR_CNT_W  = 8;
  localparam int GRAY_MAX_W = 32;

  // Callers zero-extend narrower counts; zero upper bits decode to zero,
  // so the low bits of the result are the decoded narrow count.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded bus (only one bit changes per step).
module gray_sync #(
  parameter int W      = 12,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] chain_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gray_rx.sv
// Gray-count receiver: synchronise, decode, check +1/hold steps, report lock.
module gray_rx
  import gray_pkg::*;
#(
  parameter int CBITS       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CBITS-1:0]     gray_in,
  output logic [CBITS-1:0]     bin_out,
  output logic                 valid,
  output logic                 wrap,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           dbg_state
);

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam int LW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(SYNC_STAGES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CNT - 1);

  logic [CBITS-1:0]     g_s, d, delta;
  logic [CBITS-1:0]     bin_q, prev_q;
  rx_state_e            state_q, state_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [LW-1:0]        lock_q, lock_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;
  logic                 step_err_q, step_err_d;
  logic                 step_good, step_hold, step_bad;

  gray_sync #(.W(CBITS), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gray_in),
    .q_o   (g_s)
  );

  assign d         = CBITS'(gray2bin(GRAY_MAX_W'(g_s)));
  assign delta     = d - prev_q;
  assign step_hold = (delta == '0);
  assign step_good = (delta == CBITS'(1));
  assign step_bad  = !step_hold && !step_good;

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    lock_d     = lock_q;
    err_cnt_d  = err_cnt_q;
    wrap_d     = 1'b0;
    step_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_q == FILL_LAST) state_d = TRACK;
        else                     fill_d  = fill_q + FW'(1);
      end
      TRACK: begin
        if (step_bad) begin
          step_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          lock_d  = '0;
          state_d = ERR;
        end else if (step_good && (prev_q == '1)) begin
          wrap_d = 1'b1;
        end
      end
      ERR: begin
        if (step_bad) begin
          step_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          lock_d = '0;
        end else if (step_good) begin
          // The LOCK_CNT-th consecutive good step re-locks on this edge.
          if (lock_q == LOCK_LAST) begin
            lock_d  = '0;
            state_d = TRACK;
          end else begin
            lock_d = lock_q + LW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      lock_q     <= '0;
      err_cnt_q  <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      step_err_q <= 1'b0;
      bin_q      <= '0;
      prev_q     <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      lock_q     <= lock_d;
      err_cnt_q  <= err_cnt_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      step_err_q <= step_err_d;
      bin_q      <= d;
      prev_q     <= d;
    end
  end

  assign bin_out   = bin_q;
  assign valid     = valid_q;
  assign wrap      = wrap_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_rx.sv
// Directed bench for gray_rx with CBITS=4, SYNC_STAGES=2, LOCK_CNT=4.
module tb_gray_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] gray_in = 4'd0;
  logic [3:0] bin_out;
  logic       valid, wrap, step_err;
  logic [7:0] err_cnt;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int wraps, errs;

  always #5 clk = ~clk;

  gray_rx #(.CBITS(4), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .valid     (valid),
    .wrap      (wrap),
    .step_err  (step_err),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_bin", bin_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_step_err", step_err, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // 1: count 0..15, wrap to 0, continue up to 4 (gray 0110)
    for (int i = 0; i <= 20; i++) begin
      gray_in = g(i % 16);
      tick();
      chk("t1_bin", bin_out, (i + 1 >= 3) ? (i - 2) % 16 : 0);
      chk("t1_valid", valid, (i + 1 >= 3));
      chk("t1_wrap", wrap, (i + 1 == 19));
      chk("t1_step_err", step_err, 0);
    end

    // 2: hold 0110 in TRACK
    for (int t = 0; t < 3; t++) tick();
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("t2_bin", bin_out, 4);
      chk("t2_valid", valid, 1);
      chk("t2_wrap", wrap, 0);
      chk("t2_step_err", step_err, 0);
    end
    chk("t2_err_cnt", err_cnt, 0);

    // 3: jump 4 -> 8, then relock on 9,10,11,12
    gray_in = g(8);
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("t3_step_err", step_err, (t == 3));
      chk("t3_valid", valid, (t < 3));
      chk("t3_err_cnt", err_cnt, (t >= 3) ? 1 : 0);
      chk("t3_state", dbg_state, (t >= 3) ? 2 : 1);
    end
    for (int v = 9; v <= 12; v++) begin
      gray_in = g(v);
      for (int t = 1; t <= 3; t++) begin
        tick();
        chk("t3_relock_valid", valid, (v == 12 && t == 3));
        chk("t3_relock_step_err", step_err, 0);
      end
    end
    chk("t3_err_cnt_end", err_cnt, 1);
    chk("t3_state_end", dbg_state, 1);

    // 4: climb through the wrap to 5, then down-step 5 -> 4
    wraps = 0;
    errs  = 0;
    for (int v = 13; v <= 21; v++) begin
      gray_in = g(v % 16);
      tick();
      wraps += int'(wrap);
      errs  += int'(step_err);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      wraps += int'(wrap);
      errs  += int'(step_err);
    end
    chk("t4_wraps", wraps, 1);
    chk("t4_errs", errs, 0);
    chk("t4_bin", bin_out, 5);
    chk("t4_valid", valid, 1);
    gray_in = 4'b0110;
    for (int t = 0; t < 3; t++) tick();
    chk("t4_step_err", step_err, 1);
    chk("t4_err_cnt", err_cnt, 2);
    chk("t4_valid_drop", valid, 0);
    chk("t4_state", dbg_state, 2);
    chk("t4_bin_down", bin_out, 4);

    // 5: asynchronous reset between edges
    gray_in = g(5);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("t5_bin", bin_out, 0);
    chk("t5_valid", valid, 0);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_state", dbg_state, 0);
    tick();
    #3 rst_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("t5_idle_valid", valid, (n >= 3));
      chk("t5_idle_state", dbg_state, (n >= 3) ? 1 : 0);
      chk("t5_idle_bin", bin_out, (n >= 3) ? 5 : 0);
      chk("t5_idle_step_err", step_err, 0);
    end

    // 6: 300 bad jumps saturate err_cnt at 255
    errs = 0;
    for (int k = 0; k < 302; k++) begin
      if (k < 300) gray_in = g((k % 2 == 1) ? 8 : 0);
      tick();
      errs += int'(step_err);
      if (k == 301) begin
        chk("t6_last_step_err", step_err, 1);
        chk("t6_last_err_cnt", err_cnt, 255);
      end
    end
    tick();
    chk("t6_quiet_step_err", step_err, 0);
    chk("t6_pulse_count", errs, 300);
    chk("t6_err_cnt_sat", err_cnt, 255);
    chk("t6_valid", valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
